filter_window_ctrl: RTL

FILTER_WINDOW_CTRL -- requirements
Module: filter_window_ctrl

---
 rtl/filter_window_ctrl_pkg.sv | 24 ++
 rtl/filter_window_ctrl_line_len_checker.sv | 61 ++++++
 rtl/filter_window_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/filter_window_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// filter_window_ctrl_pkg
// Shared video filter package: window-controller state encoding, the default
// operator (window) size and a small counter-width helper.
// ---------------------------------------------------------------------------
package filter_window_ctrl_pkg;

  // Controller states: waiting for a frame, filling the border rows, running
  // through the body of the frame, and the one-cycle end-of-frame marker.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } win_state_t;

  localparam int DEFAULT_OPERATOR_SIZE = 3;

  // Width of a counter that must hold values 0..n-1; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/filter_window_ctrl_line_len_checker.sv
// ---------------------------------------------------------------------------
// line_len_checker
// Measures the length of every raw input active run and raises a sticky error
// when a run ends with a length other than VIDEO_WIDTH.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset
//   in_active - raw input data-enable
//   clr_err   - single-cycle clear of the sticky flag (a new error wins)
//   err_line  - sticky line-length error
// ---------------------------------------------------------------------------
module line_len_checker
  import filter_window_ctrl_pkg::*;
#(
  parameter int VIDEO_WIDTH = 1280
) (
  input  logic clk,
  input  logic rst,
  input  logic in_active,
  input  logic clr_err,
  output logic err_line
);

  localparam int RCW = cnt_width(VIDEO_WIDTH + 2);
  localparam logic [RCW-1:0] RUN_SAT  = RCW'(VIDEO_WIDTH + 1);
  localparam logic [RCW-1:0] RUN_GOOD = RCW'(VIDEO_WIDTH);

  logic [RCW-1:0] run_cnt;
  logic           active_prev;
  logic           line_bad;

  // The run count is only cleared in the cycle after the falling edge, so at
  // the edge it still holds the full length of the run that just ended.
  assign line_bad = active_prev && !in_active && (run_cnt != RUN_GOOD);

  // Run counter saturates one past the nominal width so that overlong lines
  // stay distinguishable from correct ones without wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt     <= '0;
      active_prev <= 1'b0;
      err_line    <= 1'b0;
    end else begin
      active_prev <= in_active;
      if (in_active) begin
        if (run_cnt != RUN_SAT) begin
          run_cnt <= run_cnt + 1'b1;
        end
      end else begin
        run_cnt <= '0;
      end
      if (line_bad) begin
        err_line <= 1'b1;
      end else if (clr_err) begin
        err_line <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/filter_window_ctrl.sv
// ---------------------------------------------------------------------------
// filter_window_ctrl
// Frame/window controller for a sliding-window video filter. Tracks the
// position of each kernel result within the frame, masks the border rows and
// columns that the window cannot fully cover, and produces registered output
// timing (data-enable, line and frame pulses, frame_done). Also reports
// sticky line-length and frame-sync errors.
//
// Ports:
//   clk, rst      - rising-edge clock, synchronous active-high reset
//   in_active     - raw input data-enable (line-length checking only)
//   in_vsync      - raw input frame sync, rising edge starts a frame
//   kernel_valid  - window-kernel result valid
//   kernel_data   - window-kernel result
//   clr_err       - clears sticky error flags
//   out_active    - registered output data-enable
//   out_data      - registered, border-masked output pixel
//   out_hsync     - pulse with last pixel of each output line
//   out_vsync     - pulse with last pixel of the frame
//   frame_done    - pulse one cycle after the frame's last pixel
//   err_line      - sticky: an input line had the wrong length
//   err_sync      - sticky: in_vsync rose before the frame completed
// ---------------------------------------------------------------------------
module filter_window_ctrl
  import filter_window_ctrl_pkg::*;
#(
  parameter int VIDEO_WIDTH      = 1280,
  parameter int VIDEO_HEIGHT     = 720,
  parameter int OPERATOR_SIZE    = DEFAULT_OPERATOR_SIZE,
  parameter int VIDEO_DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_active,
  input  logic                        in_vsync,
  input  logic                        kernel_valid,
  input  logic [VIDEO_DATA_WIDTH-1:0] kernel_data,
  input  logic                        clr_err,
  output logic                        out_active,
  output logic [VIDEO_DATA_WIDTH-1:0] out_data,
  output logic                        out_hsync,
  output logic                        out_vsync,
  output logic                        frame_done,
  output logic                        err_line,
  output logic                        err_sync
);

  localparam int CW = cnt_width(VIDEO_WIDTH);
  localparam int RW = cnt_width(VIDEO_HEIGHT);
  localparam logic [CW-1:0] COL_LAST   = CW'(VIDEO_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(VIDEO_HEIGHT - 1);
  localparam logic [CW-1:0] COL_BORDER = CW'(OPERATOR_SIZE - 1);
  localparam logic [RW-1:0] ROW_BORDER = RW'(OPERATOR_SIZE - 1);

  win_state_t state, state_next;
  logic [CW-1:0] col, col_next;
  logic [RW-1:0] row, row_next;
  logic          vsync_prev;
  logic          vsync_rise;
  logic          accepting;
  logic          pixel_taken;
  logic          line_end;
  logic          frame_end;
  logic          in_border;
  logic          err_sync_next;

  logic                        active_d;
  logic [VIDEO_DATA_WIDTH-1:0] data_d;
  logic                        hsync_d;
  logic                        vsync_d;

  assign vsync_rise  = in_vsync && !vsync_prev;
  assign accepting   = (state == ST_FILL) || (state == ST_RUN);
  assign pixel_taken = accepting && kernel_valid;
  assign line_end    = (col == COL_LAST);
  assign frame_end   = line_end && (row == ROW_LAST);
  assign in_border   = (row < ROW_BORDER) || (col < COL_BORDER);

  // Next-state and position tracking. A sync rise while a frame is open
  // restarts the frame from FILL; in DONE the rise is deliberately ignored.
  always_comb begin
    state_next = state;
    col_next   = col;
    row_next   = row;
    case (state)
      ST_IDLE: begin
        if (vsync_rise) begin
          state_next = ST_FILL;
          col_next   = '0;
          row_next   = '0;
        end
      end
      ST_FILL, ST_RUN: begin
        if (vsync_rise) begin
          state_next = ST_FILL;
          col_next   = '0;
          row_next   = '0;
        end else if (kernel_valid) begin
          if (line_end) begin
            col_next = '0;
            if (row == ROW_LAST) begin
              row_next = '0;
              if (state == ST_RUN) begin
                state_next = ST_DONE;
              end
            end else begin
              row_next = row + 1'b1;
              if ((state == ST_FILL) && (row_next == ROW_BORDER)) begin
                state_next = ST_RUN;
              end
            end
          end else begin
            col_next = col + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output values for the next cycle, taken from the position of the pixel
  // being accepted now (before any counter update or sync restart).
  always_comb begin
    active_d = pixel_taken;
    data_d   = '0;
    hsync_d  = pixel_taken && line_end;
    vsync_d  = pixel_taken && frame_end;
    if (pixel_taken && !in_border) begin
      data_d = kernel_data;
    end
    err_sync_next = err_sync;
    if (vsync_rise && accepting) begin
      err_sync_next = 1'b1;
    end else if (clr_err) begin
      err_sync_next = 1'b0;
    end
  end

  // State, position and registered outputs. frame_done is registered from the
  // DONE state so that it follows the frame's out_vsync by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      col        <= '0;
      row        <= '0;
      vsync_prev <= 1'b0;
      out_active <= 1'b0;
      out_data   <= '0;
      out_hsync  <= 1'b0;
      out_vsync  <= 1'b0;
      frame_done <= 1'b0;
      err_sync   <= 1'b0;
    end else begin
      state      <= state_next;
      col        <= col_next;
      row        <= row_next;
      vsync_prev <= in_vsync;
      out_active <= active_d;
      out_data   <= data_d;
      out_hsync  <= hsync_d;
      out_vsync  <= vsync_d;
      frame_done <= (state == ST_DONE);
      err_sync   <= err_sync_next;
    end
  end

  line_len_checker #(
    .VIDEO_WIDTH(VIDEO_WIDTH)
  ) u_line_len_checker (
    .clk      (clk),
    .rst      (rst),
    .in_active(in_active),
    .clr_err  (clr_err),
    .err_line (err_line)
  );

endmodule
